// File: rtl/draw_cars.sv
// draw_cars: composites up to four ROM-backed car sprites over a video stream with a fixed
// 3-clock latency. Define DRAW_CARS_TRANSP_EN to let ROM pixels equal to TRANSP_KEY show through.
module draw_cars #(
  parameter int          CARS       = 2,
  parameter int          SPR_W      = 128,
  parameter int          SPR_H      = 64,
  parameter int          ADDR_W     = 13,
  parameter logic [11:0] TRANSP_KEY = 12'h0F0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            hcount_in,
  input  logic [10:0]            vcount_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  input  logic [CARS*11-1:0]     xpos_in,
  input  logic [CARS*11-1:0]     ypos_in,
  input  logic [CARS*12-1:0]     rgb_pixel,
  output logic [CARS*ADDR_W-1:0] pixel_addr,
  output logic [10:0]            hcount_out,
  output logic [10:0]            vcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out,
  output logic                   collision_out
);
  localparam logic [11:0] SPR_W12 = 12'(SPR_W);
  localparam logic [11:0] SPR_H12 = 12'(SPR_H);
  localparam logic [31:0] SPR_W32 = 32'(SPR_W);

  // Timing bundle, LSB first: rgb[11:0], vblnk, vsync, hblnk, hsync, vcount, hcount.
  logic [37:0] timing_in, timing_d1, timing_d2;
  logic [25:0] timing_q;
  logic [11:0] hc, vc;
  logic        vblnk_prev, load_pos;
  logic [CARS-1:0] hit, in_d1, in_d2, opaque;
  logic        hblnk_d2, vblnk_d2, blank_d2;
  logic [11:0] rgb_sel;
  logic [2:0]  n_opaque;
  logic        overlap, frame_end, acc;

  assign timing_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in};
  assign hc        = {1'b0, hcount_in};
  assign vc        = {1'b0, vcount_in};
  // Shadow positions only move at the start of vertical blanking, so a frame never tears.
  assign load_pos  = vblnk_in & ~vblnk_prev;

  for (genvar k = 0; k < CARS; k++) begin : g_ch
    logic [10:0]       xs, ys;
    logic [11:0]       x0, y0;
    logic [ADDR_W-1:0] lin, addr_q;

    assign x0     = {1'b0, xs};
    assign y0     = {1'b0, ys};
    assign hit[k] = (hc >= x0) && (hc < x0 + SPR_W12) && (vc >= y0) && (vc < y0 + SPR_H12);
    assign lin    = ADDR_W'(32'(vc - y0) * SPR_W32 + 32'(hc - x0));

    always_ff @(posedge clk) begin
      if (reset) begin
        xs     <= '0;
        ys     <= '0;
        addr_q <= '0;
      end else begin
        if (load_pos) begin
          xs <= xpos_in[11*k +: 11];
          ys <= ypos_in[11*k +: 11];
        end
        addr_q <= hit[k] ? lin : '0;
      end
    end

    assign pixel_addr[ADDR_W*k +: ADDR_W] = addr_q;

`ifdef DRAW_CARS_TRANSP_EN
    assign opaque[k] = in_d2[k] && (rgb_pixel[12*k +: 12] != TRANSP_KEY);
`else
    assign opaque[k] = in_d2[k];
`endif
  end

  assign vblnk_d2  = timing_d2[12];
  assign hblnk_d2  = timing_d2[14];
  assign blank_d2  = hblnk_d2 | vblnk_d2;
  assign frame_end = vblnk_d2 & ~timing_q[0];

  // Walk from the highest index down so the lowest-index opaque channel wins.
  always_comb begin
    rgb_sel  = timing_d2[11:0];
    n_opaque = '0;
    for (int k = CARS - 1; k >= 0; k--) begin
      if (opaque[k]) rgb_sel = rgb_pixel[12*k +: 12];
      n_opaque = n_opaque + 3'(opaque[k]);
    end
  end

  assign overlap = (n_opaque >= 3'd2) && !blank_d2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vblnk_prev    <= 1'b0;
      in_d1         <= '0;
      in_d2         <= '0;
      timing_d1     <= '0;
      timing_d2     <= '0;
      timing_q      <= '0;
      rgb_out       <= '0;
      acc           <= 1'b0;
      collision_out <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      in_d1      <= hit;
      in_d2      <= in_d1;
      timing_d1  <= timing_in;
      timing_d2  <= timing_d1;
      timing_q   <= timing_d2[37:12];
      rgb_out    <= blank_d2 ? 12'h000 : rgb_sel;
      if (frame_end) begin
        collision_out <= acc | overlap;
        acc           <= 1'b0;
      end else begin
        acc <= acc | overlap;
      end
    end
  end

  assign {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} = timing_q;
endmodule

// File: tb/tb_draw_cars.sv
// Bench for draw_cars: directed vector table, hand-written frame/edge/reset sequences and a
// randomized pixel stream checked against a per-pixel sprite model with a 3-deep expected queue.
module tb_draw_cars;
  localparam int CARS   = 2;
  localparam int SPR_W  = 128;
  localparam int SPR_H  = 64;
  localparam int ADDR_W = 13;
  localparam int EW     = 39;

  logic clk = 1'b0;
  logic reset;
  logic [10:0] hcount_in, vcount_in;
  logic hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [CARS*11-1:0] xpos_in, ypos_in;
  logic [CARS*12-1:0] rgb_pixel;
  logic [CARS*ADDR_W-1:0] pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic collision_out;

  always #5 clk = ~clk;

  draw_cars #(.CARS(CARS), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .TRANSP_KEY(12'h0F0)) dut (
    .clk(clk), .reset(reset),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .rgb_pixel(rgb_pixel),
    .pixel_addr(pixel_addr), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .collision_out(collision_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rom_mode;
  logic [11:0] rom_col [CARS];
  logic [EW-1:0] exp_q[$];

  // ROM contents: mode 0 is an address-dependent pattern, mode 1 a solid colour per channel.
  function automatic logic [11:0] pat(int k, int a);
    return 12'((a * 37 + k * 1111 + 3) ^ (a >> 5));
  endfunction

  function automatic logic [11:0] rom_val(int k, int a);
    return (rom_mode == 0) ? pat(k, a) : rom_col[k];
  endfunction

  always @(posedge clk)
    for (int k = 0; k < CARS; k++)
      rgb_pixel[12*k +: 12] <= rom_val(k, int'(pixel_addr[ADDR_W*k +: ADDR_W]));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int h, int v, bit hb, bit vb, logic [11:0] bg);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = 1'((h >> 2) & 1);
    vsync_in  = 1'((v >> 1) & 1);
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = bg;
  endtask

  task automatic set_pos(int k, int x, int y);
    xpos_in[11*k +: 11] = 11'(x);
    ypos_in[11*k +: 11] = 11'(y);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pos();
    drive(0, 0, 0, 0, 12'h000); tick();
    drive(0, 0, 0, 1, 12'h000); tick();
    drive(0, 0, 0, 0, 12'h000); tick();
  endtask

  // Hold one pixel for three edges so the output reflects it, then compare rgb_out.
  task automatic check_px(string name, int h, int v, bit hb, bit vb, logic [11:0] bg,
                          logic [11:0] exp);
    drive(h, v, hb, vb, bg);
    repeat (3) tick();
    chk(name, rgb_out, exp);
  endtask

  // Reference model state: shadow positions, collision accumulator and the displayed flag.
  int m_x[CARS], m_y[CARS];
  bit m_prev_vb, m_acc, m_coll;

  task automatic model_reset();
    for (int k = 0; k < CARS; k++) begin m_x[k] = 0; m_y[k] = 0; end
    m_prev_vb = 0; m_acc = 0; m_coll = 0;
  endtask

  task automatic model_step(int h, int v, bit hb, bit vb, logic [11:0] bg,
                            output logic [EW-1:0] e);
    int n;
    bit found, ov, op;
    logic [11:0] col, c;
    n = 0; found = 0; col = bg;
    for (int k = 0; k < CARS; k++) begin
      if (h >= m_x[k] && h < m_x[k] + SPR_W && v >= m_y[k] && v < m_y[k] + SPR_H) begin
        c  = rom_val(k, (v - m_y[k]) * SPR_W + (h - m_x[k]));
        op = 1;
`ifdef DRAW_CARS_TRANSP_EN
        if (c == 12'h0F0) op = 0;
`endif
        if (op) begin
          n++;
          if (!found) begin col = c; found = 1; end
        end
      end
    end
    ov = (n >= 2) && !hb && !vb;
    if (vb && !m_prev_vb) begin
      m_coll = m_acc | ov;
      m_acc  = 0;
      for (int k = 0; k < CARS; k++) begin
        m_x[k] = int'(xpos_in[11*k +: 11]);
        m_y[k] = int'(ypos_in[11*k +: 11]);
      end
    end else begin
      m_acc = m_acc | ov;
    end
    m_prev_vb = vb;
    e = {11'(h), 11'(v), 1'((h >> 2) & 1), hb, 1'((v >> 1) & 1), vb,
         (hb || vb) ? 12'h000 : col, m_coll};
  endtask

  typedef struct {
    int h; int v; bit hb; bit vb; logic [11:0] bg; logic [11:0] exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [EW-1:0] e, act;
    bit vb_r;
    int h, v, eh;
    logic [11:0] exp_rgb;

    reset = 1'b1;
    drive(0, 0, 0, 0, 12'h000);
    xpos_in = '0; ypos_in = '0;
    rom_mode = 1;
    rom_col = '{12'hF00, 12'h00F};
    repeat (2) tick();
    chk("reset_rgb", rgb_out, 0);
    chk("reset_hcount", hcount_out, 0);
    chk("reset_collision", collision_out, 0);
    chk("reset_addr", pixel_addr, 0);
    reset = 1'b0;

    // Directed table: car0 at (100,100), car1 at (150,120), solid colours.
    tbl[0]  = '{50,  50,  1'b0, 1'b0, 12'h123, 12'h123};
    tbl[1]  = '{100, 100, 1'b0, 1'b0, 12'h123, 12'hF00};
    tbl[2]  = '{227, 163, 1'b0, 1'b0, 12'h123, 12'hF00};
    tbl[3]  = '{228, 100, 1'b0, 1'b0, 12'h5A5, 12'h5A5};
    tbl[4]  = '{100, 164, 1'b0, 1'b0, 12'h5A5, 12'h5A5};
    tbl[5]  = '{99,  100, 1'b0, 1'b0, 12'h321, 12'h321};
    tbl[6]  = '{150, 120, 1'b0, 1'b0, 12'h123, 12'hF00};
    tbl[7]  = '{250, 130, 1'b0, 1'b0, 12'h123, 12'h00F};
    tbl[8]  = '{277, 183, 1'b0, 1'b0, 12'h123, 12'h00F};
    tbl[9]  = '{278, 183, 1'b0, 1'b0, 12'h777, 12'h777};
    tbl[10] = '{250, 130, 1'b1, 1'b0, 12'h123, 12'h000};
    tbl[11] = '{250, 130, 1'b0, 1'b1, 12'h123, 12'h000};
    set_pos(0, 100, 100); set_pos(1, 150, 120);
    load_pos();
    for (int i = 0; i < 12; i++)
      check_px($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb,
               tbl[i].bg, tbl[i].exp);

    // Priority with both cars stacked, and the collision flag over the next frame.
    set_pos(0, 100, 100); set_pos(1, 100, 100);
    load_pos();
    check_px("pri_in", 110, 110, 0, 0, 12'h123, 12'hF00);
    chk("coll_prev_frame", collision_out, 0);
    check_px("pri_corner", 227, 163, 0, 0, 12'h123, 12'hF00);
    set_pos(1, 500, 300);
    check_px("pri_vblank", 110, 110, 0, 1, 12'h123, 12'h000);
    chk("coll_set", collision_out, 1);
    check_px("pri_car1_alone", 600, 350, 0, 0, 12'h123, 12'h00F);
    chk("coll_hold", collision_out, 1);
    check_px("pri_vblank2", 600, 350, 0, 1, 12'h123, 12'h000);
    chk("coll_clear", collision_out, 0);

    // Colour-key channel stacked over a solid one.
    rom_col = '{12'h0F0, 12'h00F};
    set_pos(0, 100, 100); set_pos(1, 100, 100);
    load_pos();
`ifdef DRAW_CARS_TRANSP_EN
    check_px("transp_pix", 120, 120, 0, 0, 12'h123, 12'h00F);
    check_px("transp_vb", 120, 120, 0, 1, 12'h123, 12'h000);
    chk("transp_coll", collision_out, 0);
`else
    check_px("transp_pix", 120, 120, 0, 0, 12'h123, 12'h0F0);
    check_px("transp_vb", 120, 120, 0, 1, 12'h123, 12'h000);
    chk("transp_coll", collision_out, 1);
`endif
    rom_col = '{12'hF00, 12'h00F};

    // Position change mid-frame only takes effect after the next vblank rise.
    set_pos(0, 256, 150); set_pos(1, 1500, 1500);
    load_pos();
    check_px("fs_old_in", 260, 200, 0, 0, 12'h123, 12'hF00);
    set_pos(0, 300, 150);
    check_px("fs_old_still", 256, 200, 0, 0, 12'h123, 12'hF00);
    check_px("fs_new_not_yet", 390, 200, 0, 0, 12'h123, 12'h123);
    load_pos();
    check_px("fs_new", 390, 200, 0, 0, 12'h123, 12'hF00);
    check_px("fs_old_gone", 260, 200, 0, 0, 12'h123, 12'h123);

    // Right-edge and top-of-range positions: no wrap to column 0.
    set_pos(0, 1000, 0);
    load_pos();
    check_px("edge_1000", 1000, 10, 0, 0, 12'h123, 12'hF00);
    check_px("edge_1023", 1023, 10, 0, 0, 12'h123, 12'hF00);
    check_px("edge_1023_hb", 1023, 10, 1, 0, 12'h123, 12'h000);
    check_px("edge_col0", 0, 10, 0, 0, 12'h123, 12'h123);
    check_px("edge_1127", 1127, 10, 0, 0, 12'h123, 12'hF00);
    check_px("edge_1128", 1128, 10, 0, 0, 12'h123, 12'h123);
    set_pos(0, 2000, 0);
    load_pos();
    check_px("edge_2047", 2047, 10, 0, 0, 12'h123, 12'hF00);
    check_px("nowrap_0", 0, 10, 0, 0, 12'h123, 12'h123);
    check_px("nowrap_79", 79, 10, 0, 0, 12'h123, 12'h123);

    // Continuous scan with addressed ROM data: 3-clock alignment of timing and pixels.
    rom_mode = 0;
    set_pos(0, 256, 400);
    load_pos();
    for (int hh = 250; hh <= 270; hh++) begin
      drive(hh, 401, 0, 0, 12'h123);
      tick();
      if (hh >= 252) begin
        eh = hh - 2;
        exp_rgb = (eh >= 256) ? pat(0, SPR_W + eh - 256) : 12'h123;
        chk($sformatf("scan_h%0d", eh), hcount_out, eh);
        chk($sformatf("scan_rgb%0d", eh), rgb_out, exp_rgb);
      end
    end
    chk("scan_vcount", vcount_out, 401);

    // Mid-frame reset: everything clears next edge, shadows stay at 0 afterwards.
    rom_mode = 1;
    drive(300, 420, 0, 0, 12'h123); tick();
    reset = 1'b1; tick();
    chk("mrst_rgb", rgb_out, 0);
    chk("mrst_hcount", hcount_out, 0);
    chk("mrst_vcount", vcount_out, 0);
    chk("mrst_addr", pixel_addr, 0);
    chk("mrst_sync", {hsync_out, hblnk_out, vsync_out, vblnk_out}, 0);
    reset = 1'b0;
    check_px("mrst_shadow0", 5, 5, 0, 0, 12'h123, 12'hF00);
    check_px("mrst_outside", 200, 5, 0, 0, 12'h123, 12'h123);

    // Randomized pixel stream against the model.
    rom_mode = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    exp_q.delete();
    exp_q.push_back('0); exp_q.push_back('0);
    vb_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1; tick();
        chk("rnd_reset_rgb", rgb_out, 0);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        exp_q.push_back('0); exp_q.push_back('0);
      end
      if ($urandom_range(0, 39) == 0) vb_r = ~vb_r;
      for (int k = 0; k < CARS; k++)
        set_pos(k, ($urandom_range(0, 3) != 0) ? $urandom_range(0, 300) : $urandom_range(1950, 2047),
                $urandom_range(0, 150));
      h = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 450) : $urandom_range(1900, 2047);
      v = $urandom_range(0, 250);
      drive(h, v, ($urandom_range(0, 7) == 0), vb_r, 12'($urandom));
      model_step(h, v, hblnk_in, vblnk_in, rgb_in, e);
      exp_q.push_back(e);
      tick();
      act = {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out, collision_out};
      chk($sformatf("rnd%0d", i), act, exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/draw_cars.md
DRAW_CARS -- requirements
Module: draw_cars

Interface
REQ-001 SHALL have parameters:
- CARS, default 2, number of car channels, legal 1..4.
- SPR_W, default 128, sprite width in pixels.
- SPR_H, default 64, sprite height in pixels.
- ADDR_W, default 13, per-channel ROM address width; SPR_W*SPR_H <= 2^ADDR_W.
- TRANSP_KEY, default 12'h0F0, transparent colour key.

REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- hcount_in, vcount_in  in  11 each  pixel coordinates.
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing signals.
- rgb_in  in  12  background colour.
- xpos_in, ypos_in  in  CARS*11 each  sprite top-left corners; channel k at bits [11k+10:11k].
- rgb_pixel  in  CARS*12  ROM data, channel k at [12k+11:12k], one-cycle synchronous read.
- pixel_addr  out  CARS*ADDR_W  ROM address per channel.
- hcount_out, vcount_out  out  11 each  delayed coordinates.
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1 each  delayed timing signals.
- rgb_out  out  12  composited colour.
- collision_out  out  1  previous-frame overlap flag.

REQ-003 SHALL state that clock and reset are decided: one clock clk; reset synchronous, active-high.

Function
REQ-004 SHALL give every output a fixed latency of 3 clocks from input sample to output.
- Edge 1: register pixel_addr.
- Edge 2: ROM returns data.
- Edge 3: register outputs.

REQ-005 SHALL delay hcount, vcount, hsync, hblnk, vsync, vblnk and rgb_in by exactly 3 clocks, so they stay aligned with rgb_out.

REQ-006 SHALL keep shadow copies of all xpos/ypos and load them only on the cycle vblnk_in goes 0->1, so sprites never tear mid-frame.

REQ-007 SHALL set inside_k at edge 1 when both hold, using 12-bit arithmetic, with no wrap for x+SPR_W > 2047:
- xs_k <= hcount_in < xs_k+SPR_W
- ys_k <= vcount_in < ys_k+SPR_H

REQ-008 SHALL compute pixel_addr for channel k at edge 1:
- When inside_k: (vcount_in-ys_k)*SPR_W + (hcount_in-xs_k), truncated to ADDR_W.
- Otherwise: 0.

REQ-009 SHALL pipeline inside_k by 2 clocks so it is aligned with rgb_pixel.

REQ-010 SHALL mark channel k opaque when aligned inside_k=1 (and transparency test per REQ-019).

REQ-011 SHALL select rgb_out with fixed priority: lowest-index opaque channel wins; if no channel is opaque, the delayed rgb_in is used.

REQ-012 SHALL force rgb_out=12'h000 when the delayed hblnk or vblnk is 1, overriding sprites and background.

REQ-013 SHALL set an internal accumulator when two or more channels are opaque on a non-blanked pixel.

REQ-014 SHALL, on the cycle vblnk_out goes 0->1:
- load collision_out from the accumulator OR the current-cycle overlap;
- clear the accumulator.
collision_out then holds constant for the whole next frame.

REQ-015 SHALL handle a position update and a pixel inside the window on the same cycle by using the old shadow value for that pixel.

REQ-016 SHALL, with CARS=1, never assert collision_out.

Reset
REQ-017 SHALL, while reset=1 at a rising edge, clear to 0:
- all pipeline registers;
- shadow positions;
- accumulator;
- pixel_addr, rgb_out, all timing outputs, collision_out.

REQ-018 SHALL, on reset asserted mid-frame, take effect on the next edge; valid outputs resume 3 clocks after release, with shadows at 0 until the next vblnk_in rising edge.

Configuration
REQ-019 SHALL implement macro DRAW_CARS_TRANSP_EN:
- When defined: a channel whose aligned rgb_pixel equals TRANSP_KEY is not opaque. It is ignored for priority and collision, and lower-priority channels or background show through.
- When undefined: no key compare; every inside pixel is opaque.

Verification
REQ-020 SHALL cover a latency check: CARS=2, car0 at (256,400), rgb_in=12'h123, hcount 0..1343 → outputs equal inputs delayed 3; car0 ROM data appears at hcount_out 256..383, vcount_out 400..463.

REQ-021 SHALL cover priority: car0 and car1 both at (100,100), ROM0=12'hF00, ROM1=12'h00F → rgb_out=12'hF00 over the 128x64 window; collision_out=1 during the following frame.

REQ-022 SHALL cover transparency: macro defined, ROM0=12'h0F0 everywhere, car1 at the same position with 12'h00F → rgb_out=12'h00F and collision_out=0; macro undefined → 12'h0F0 and collision_out=1.

REQ-023 SHALL cover frame-synchronous update: change xpos_in[10:0] from 256 to 300 at vcount_in=200 → current frame still drawn at 256; next frame drawn at 300.

REQ-024 SHALL cover edge and reset cases:
- xpos=1000 with 1024-wide active area → pixels 1000..1023 drawn, no wrap to column 0.
- reset pulse at vcount 300 → all outputs 0 the next cycle; aligned output 3 clocks after release.
